// File: rtl/hazard_pkg.sv
// Shared types and forwarding-select encodings for the pipeline hazard unit.
package hazard_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel_e.sv
// Execute-stage ALU operand forwarding select; M-stage result wins over WB.
module fwd_sel_e
  import hazard_pkg::*;
(
  input  reg_idx_t   src,
  input  reg_idx_t   writeregM,
  input  logic       regwriteM,
  input  reg_idx_t   writeregW,
  input  logic       regwriteW,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if ((src != '0) && (src == writeregM) && regwriteM) begin
      sel = FWD_MEM;
    end else if ((src != '0) && (src == writeregW) && regwriteW) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection, forwarding control and saturating stall-event counters
// for the five-stage MIPS pipeline.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  reg_idx_t    rsD,
  input  reg_idx_t    rtD,
  input  reg_idx_t    rsE,
  input  reg_idx_t    rtE,
  input  reg_idx_t    writeregE,
  input  reg_idx_t    writeregM,
  input  reg_idx_t    writeregW,
  input  logic        regwriteE,
  input  logic        regwriteM,
  input  logic        regwriteW,
  input  logic        memtoregE,
  input  logic        memtoregM,
  input  logic        branchD,
  input  logic        bneD,
  output logic        forwardaD,
  output logic        forwardbD,
  output logic [1:0]  forwardaE,
  output logic [1:0]  forwardbE,
  output logic        stallF,
  output logic        stallD,
  output logic        flushE,
  output logic [15:0] lwstall_cnt,
  output logic [15:0] brstall_cnt
);

  logic        lwstall;
  logic        branchstall;
  logic        br_dep_e;
  logic        br_dep_m;
  logic [15:0] lwstall_cnt_d, lwstall_cnt_q;
  logic [15:0] brstall_cnt_d, brstall_cnt_q;

  fwd_sel_e u_fwd_a (
    .src       (rsE),
    .writeregM (writeregM),
    .regwriteM (regwriteM),
    .writeregW (writeregW),
    .regwriteW (regwriteW),
    .sel       (forwardaE)
  );

  fwd_sel_e u_fwd_b (
    .src       (rtE),
    .writeregM (writeregM),
    .regwriteM (regwriteM),
    .writeregW (writeregW),
    .regwriteW (regwriteW),
    .sel       (forwardbE)
  );

  always_comb begin
    forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    // Load-use check deliberately has no $0 exclusion.
    lwstall  = memtoregE && ((rsD == rtE) || (rtD == rtE));
    br_dep_e = regwriteE && ((writeregE == rsD) || (writeregE == rtD));
    br_dep_m = memtoregM && ((writeregM == rsD) || (writeregM == rtD));
    branchstall = (branchD || bneD) && (br_dep_e || br_dep_m);

    stallF = lwstall || branchstall;
    stallD = lwstall || branchstall;
    flushE = lwstall || branchstall;
  end

  always_comb begin
    lwstall_cnt_d = lwstall_cnt_q;
    brstall_cnt_d = brstall_cnt_q;
    if (reset) begin
      lwstall_cnt_d = '0;
      brstall_cnt_d = '0;
    end else begin
      if (lwstall && (lwstall_cnt_q != '1)) begin
        lwstall_cnt_d = lwstall_cnt_q + 16'd1;
      end
      if (branchstall && (brstall_cnt_q != '1)) begin
        brstall_cnt_d = brstall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    lwstall_cnt_q <= lwstall_cnt_d;
    brstall_cnt_q <= brstall_cnt_d;
  end

  assign lwstall_cnt = lwstall_cnt_q;
  assign brstall_cnt = brstall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed self-checking bench for hazard_unit.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic        branchD, bneD;
  logic        forwardaD, forwardbD, stallF, stallD, flushE;
  logic [1:0]  forwardaE, forwardbE;
  logic [15:0] lwstall_cnt, brstall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          m_lw = 0;
  int          m_br = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .bneD(bneD),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .lwstall_cnt(lwstall_cnt), .brstall_cnt(brstall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: operand select as an integer 0=RF, 1=WB, 2=MEM.
  function automatic int ref_fwd_e(input int src);
    if (src != 0 && regwriteM && src == int'(writeregM)) return 2;
    if (src != 0 && regwriteW && src == int'(writeregW)) return 1;
    return 0;
  endfunction

  function automatic bit ref_lw();
    return memtoregE && (rsD == rtE || rtD == rtE);
  endfunction

  function automatic bit ref_br();
    bit uses_e, uses_m;
    uses_e = regwriteE && (writeregE == rsD || writeregE == rtD);
    uses_m = memtoregM && (writeregM == rsD || writeregM == rtD);
    return (branchD || bneD) && (uses_e || uses_m);
  endfunction

  function automatic int ref_word();
    int w, stall;
    stall = (ref_lw() || ref_br()) ? 1 : 0;
    w = 0;
    w += (rsD != 0 && regwriteM && rsD == writeregM) ? 256 : 0;
    w += (rtD != 0 && regwriteM && rtD == writeregM) ? 128 : 0;
    w += ref_fwd_e(int'(rsE)) * 32;
    w += ref_fwd_e(int'(rtE)) * 8;
    w += stall * 7;
    return w;
  endfunction

  function automatic logic [8:0] dut_word();
    return {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, flushE};
  endfunction

  task automatic check_word(input string tag);
    #1;
    check(tag, 32'(dut_word()), 32'(ref_word()));
  endtask

  // One clock: model counters advance from the inputs held across the edge.
  task automatic tick(input bit do_check);
    bit lw, br;
    lw = ref_lw();
    br = ref_br();
    @(posedge clk);
    if (reset) begin
      m_lw = 0;
      m_br = 0;
    end else begin
      if (lw && m_lw < 65535) m_lw++;
      if (br && m_br < 65535) m_br++;
    end
    #1;
    if (do_check) begin
      check("lwstall_cnt", 32'(lwstall_cnt), 32'(m_lw));
      check("brstall_cnt", 32'(brstall_cnt), 32'(m_br));
    end
  endtask

  task automatic clear_inputs();
    rsD = 5'd1; rtD = 5'd2; rsE = 5'd3; rtE = 5'd4;
    writeregE = 5'd5; writeregM = 5'd6; writeregW = 5'd7;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; branchD = 0; bneD = 0;
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    int prev, guard;
    reset = 1'b1;
    clear_inputs();
    #2;
    tick(1'b0);
    check("reset_lw", 32'(lwstall_cnt), 32'd0);
    check("reset_br", 32'(brstall_cnt), 32'd0);
    reset = 1'b0;

    // No hazard
    check_word("no_hazard_word");
    check("no_hazard_zero", 32'(dut_word()), 32'd0);
    tick(1'b1);
    check("no_hazard_cnt", 32'(lwstall_cnt), 32'd0);

    // E-stage forward priority
    rsE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    #1 check("fwdE_mem", 32'(forwardaE), 32'd2);
    regwriteM = 0;
    #1 check("fwdE_wb", 32'(forwardaE), 32'd1);
    rsE = 0;
    #1 check("fwdE_r0", 32'(forwardaE), 32'd0);
    clear_inputs();

    // Load-use held three cycles
    rtE = 8; memtoregE = 1; rsD = 8;
    #1 check("lw_stall", 32'({stallF, stallD, flushE}), 32'd7);
    prev = int'(lwstall_cnt);
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1);
      check("lw_inc", 32'(lwstall_cnt), 32'(prev + i));
    end
    clear_inputs();

    // Branch stalls
    branchD = 1; rsD = 9; writeregE = 9; regwriteE = 1;
    #1 check("br_stall_e", 32'(stallF), 32'd1);
    bneD = 1; branchD = 0; memtoregM = 1; writeregM = 10; rtD = 10;
    #1 check("br_stall_m", 32'(stallD), 32'd1);
    tick(1'b1);
    bneD = 0;
    #1 check("br_nostall", 32'({stallF, stallD, flushE}), 32'd0);
    clear_inputs();

    // D-stage forward
    rtD = 12; writeregM = 12; regwriteM = 1; branchD = 1;
    #1 check("fwdD_b", 32'(forwardbD), 32'd1);
    check("fwdD_nostall", 32'(flushE), 32'd0);
    rtD = 0; writeregM = 0;
    #1 check("fwdD_r0", 32'(forwardbD), 32'd0);
    tick(1'b1);
    clear_inputs();

    // Randomized sweep against the model
    for (int i = 0; i < 2000; i++) begin
      rsD = rnd_reg(); rtD = rnd_reg(); rsE = rnd_reg(); rtE = rnd_reg();
      writeregE = rnd_reg(); writeregM = rnd_reg(); writeregW = rnd_reg();
      regwriteE = 1'($urandom); regwriteM = 1'($urandom);
      regwriteW = 1'($urandom); memtoregE = 1'($urandom);
      memtoregM = 1'($urandom); branchD = 1'($urandom); bneD = 1'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      check_word("rand_word");
      tick(1'b1);
    end
    reset = 1'b0;

    // Saturation: hold load-use plus branch stall until lwstall saturates
    clear_inputs();
    rtE = 8; memtoregE = 1; rsD = 8;
    branchD = 1; writeregE = 8; regwriteE = 1;
    guard = 0;
    while (m_lw != 65535 && guard < 70000) begin
      tick(1'b0);
      guard++;
    end
    check("sat_reach", 32'(lwstall_cnt), 32'hFFFF);
    tick(1'b1);
    check("sat_hold_lw", 32'(lwstall_cnt), 32'hFFFF);
    check("sat_hold_br", 32'(brstall_cnt), 32'hFFFF);

    // Reset beats a concurrent stall
    reset = 1'b1;
    tick(1'b1);
    check("rst_lw", 32'(lwstall_cnt), 32'd0);
    check("rst_br", 32'(brstall_cnt), 32'd0);
    check_word("rst_word_unaffected");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and forwarding control for the five-stage pipelined MIPS core. It compares register specifiers across the Decode, Execute, Memory and Writeback stages. From them it produces the forwarding selects for the Decode-stage branch comparator and the Execute-stage ALU operands, plus the stall/flush controls for load-use and branch-operand hazards. Hazard outputs are purely combinational. A small clocked block counts stall events for performance monitoring.

## Interface
- No parameters.
- clk  in  1  pipeline clock; used only by the stall counters.
- reset  in  1  synchronous, active-high; clears the stall counters.
- rsD, rtD  in  5  source registers of the Decode-stage instruction.
- rsE, rtE  in  5  source registers of the Execute-stage instruction.
- writeregE, writeregM, writeregW  in  5  destination registers in E/M/W.
- regwriteE, regwriteM, regwriteW  in  1  register-write enables in E/M/W.
- memtoregE, memtoregM  in  1  load-instruction flags in E/M.
- branchD, bneD  in  1  Decode holds beq / bne.
- forwardaD, forwardbD  out  1  forward the ALUOut of the M stage to branch comparator operand A / B.
- forwardaE, forwardbE  out  2  ALU operand select: 00 register file, 01 WB result, 10 M-stage ALUOut.
- stallF, stallD  out  1  hold PC / IF-ID register.
- flushE  out  1  clear ID-EX register (insert bubble).
- lwstall_cnt, brstall_cnt  out  16  saturating event counters.

## Operation
- forwardaD = (rsD≠0) ∧ (rsD==writeregM) ∧ regwriteM. forwardbD is the same with rtD.
- forwardaE:
  - 10 if (rsE≠0) ∧ (rsE==writeregM) ∧ regwriteM;
  - else 01 if (rsE≠0) ∧ (rsE==writeregW) ∧ regwriteW;
  - else 00.
  - M has priority over W.
- forwardbE is identical with rtE.
- lwstall = memtoregE ∧ ((rsD==rtE) ∨ (rtD==rtE)). There is no $0 exclusion.
- branchstall = (branchD ∨ bneD) ∧ (A ∨ B):
  - A = regwriteE ∧ (writeregE==rsD ∨ writeregE==rtD);
  - B = memtoregM ∧ (writeregM==rsD ∨ writeregM==rtD).
- stallF = stallD = flushE = lwstall ∨ branchstall.
- Counters:
  - On each rising clk, lwstall_cnt increments when lwstall is high.
  - brstall_cnt increments when branchstall is high.
  - Both saturate at 0xFFFF.
  - reset has priority and loads 0.
- The 9-bit output vector {forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, flushE} is the verification check word.

## Timing
- All hazard/forward outputs are combinational from the current inputs. They have zero latency and no dependence on clk or reset.
- Outputs are valid within the same cycle, before the next rising edge.
- Reset value:
  - Counters are 0 on the cycle after reset is sampled high.
  - Hazard outputs are unaffected by reset.
- Counters update one cycle after the stall condition is present. The value read in cycle n reflects stalls through cycle n-1.
- Simultaneous lwstall and branchstall: both counters increment, and the stall outputs are asserted once.
- reset asserted in the middle of operation clears the counters that edge, regardless of any concurrent stall.

## Structure
- Package hazard_pkg holds:
  - the forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the 5-bit register-index type.
- Sub-module fwd_sel_e:
  - inputs: src, writeregM, regwriteM, writeregW, regwriteW;
  - output: 2-bit select;
  - instantiated twice, for rsE and rtE.
- The D-stage forwarding, the stall equations and the counters stay in the top module.

## Test plan
- No-hazard case:
  - Stimulus: all specifiers distinct and nonzero, all enables 0.
  - Required: check word 000000000, counters unchanged.
- E-stage forward priority:
  - Stimulus: rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1.
  - Required: forwardaE=10.
  - Then with regwriteM=0: forwardaE=01.
  - Then with rsE=0 (other inputs kept): forwardaE=00.
- Load-use:
  - Stimulus: rtE=8, memtoregE=1, rsD=8.
  - Required: stallF=stallD=flushE=1. lwstall_cnt increments by 1 per cycle held.
- Branch stall:
  - Stimulus: branchD=1, rsD=9, writeregE=9, regwriteE=1.
  - Required: stall=1.
  - Then with bneD=1, branchD=0, memtoregM=1, writeregM=10, rtD=10 (other inputs kept): stall=1. With all of branchD, bneD = 0: stall=0.
- D-stage forward:
  - Stimulus: rtD=12, writeregM=12, regwriteM=1, branchD=1, no E hazard.
  - Required: forwardbD=1, no stall. With rtD=0 and writeregM=0: forwardbD=0.
- Counter reset and saturation:
  - Hold lwstall until lwstall_cnt=0xFFFF, then hold one more cycle: the count stays 0xFFFF.
  - Assert reset: both counters read 0 next cycle.
